// File: rtl/aes_key_expand_128_pkg.sv
// Shared constants for the AES-128 key expander: round count, rcon bytes,
// forward S-box table and inverse S-box lookup, plus the expander state type.
package aes_key_expand_128_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] ROUNDS = 4'd10;

    // Top byte of rcon for the expansion producing round key i+1
    localparam logic [7:0] RCON_TABLE [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX_TABLE [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Inverse S-box table held inside a function so it costs nothing unless called
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] tbl [0:255];
        tbl = '{
            8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
            8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
            8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
            8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
            8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
            8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
            8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
            8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
            8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
            8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
            8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
            8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
            8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
            8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
            8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
            8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
        };
        return tbl[a];
    endfunction

endpackage

// File: rtl/aes_key_expand_128_if.sv
// Key-load, round-key and inverse S-box lookup signals of the AES-128 key expander.
// master drives key load and lookup input; slave is the expander itself.
interface aes_key_expand_128_if;
    logic         kld;
    logic [127:0] key;
    logic [31:0]  wo_0;
    logic [31:0]  wo_1;
    logic [31:0]  wo_2;
    logic [31:0]  wo_3;
    logic [3:0]   rnd;
    logic [7:0]   isb_in;
    logic [7:0]   isb_out;

    modport master (
        output kld, key, isb_in,
        input  wo_0, wo_1, wo_2, wo_3, rnd, isb_out
    );

    modport slave (
        input  kld, key, isb_in,
        output wo_0, wo_1, wo_2, wo_3, rnd, isb_out
    );
endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox
    import aes_key_expand_128_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    assign y = SBOX_TABLE[a];
endmodule

// File: rtl/aes_key_expand_128_top.sv
// AES-128 key expander producing one round key per clock after a key load.
// Define AES_KEY_EXP_INV_SBOX_EN to enable the inverse S-box lookup port.
module aes_key_expand_128_top
    import aes_key_expand_128_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    aes_key_expand_128_if.slave  bus
);

    state_t            state_reg, state_next;
    logic [3:0][31:0]  w_reg, w_next;
    logic [3:0]        rnd_reg, rnd_next;
    logic [31:0]       rcon_reg, rcon_next;
    logic [3:0]        rcon_idx;
    logic [31:0]       rot_word, sub_word, t_word;
    logic [31:0]       e0, e1, e2, e3;

    assign rot_word = {w_reg[3][23:0], w_reg[3][31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .a (rot_word[gi*8 +: 8]),
                .y (sub_word[gi*8 +: 8])
            );
        end
    endgenerate

    assign t_word = sub_word ^ rcon_reg;
    assign e0     = w_reg[0] ^ t_word;
    assign e1     = e0 ^ w_reg[1];
    assign e2     = e1 ^ w_reg[2];
    assign e3     = e2 ^ w_reg[3];

    // Clamp so the lookup stays in range on the final expansion step
    assign rcon_idx = (rnd_reg >= ROUNDS - 4'd1) ? ROUNDS - 4'd1 : rnd_reg + 4'd1;

    always_comb begin
        state_next = state_reg;
        w_next     = w_reg;
        rnd_next   = rnd_reg;
        rcon_next  = rcon_reg;
        if (bus.kld) begin
            w_next[0]  = bus.key[127:96];
            w_next[1]  = bus.key[95:64];
            w_next[2]  = bus.key[63:32];
            w_next[3]  = bus.key[31:0];
            rnd_next   = 4'd0;
            rcon_next  = {RCON_TABLE[0], 24'h0};
            state_next = ST_RUN;
        end else if (state_reg == ST_RUN) begin
            w_next[0] = e0;
            w_next[1] = e1;
            w_next[2] = e2;
            w_next[3] = e3;
            rnd_next  = rnd_reg + 4'd1;
            rcon_next = {RCON_TABLE[rcon_idx], 24'h0};
            if (rnd_reg == ROUNDS - 4'd1) begin
                state_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            w_reg     <= '0;
            rnd_reg   <= 4'd0;
            rcon_reg  <= 32'h0;
        end else begin
            state_reg <= state_next;
            w_reg     <= w_next;
            rnd_reg   <= rnd_next;
            rcon_reg  <= rcon_next;
        end
    end

    assign bus.wo_0 = w_reg[0];
    assign bus.wo_1 = w_reg[1];
    assign bus.wo_2 = w_reg[2];
    assign bus.wo_3 = w_reg[3];
    assign bus.rnd  = rnd_reg;

`ifdef AES_KEY_EXP_INV_SBOX_EN
    assign bus.isb_out = inv_sbox(bus.isb_in);
`else
    logic unused_isb_in;
    assign unused_isb_in = ^bus.isb_in;
    assign bus.isb_out   = 8'h00;
`endif

endmodule

// File: tb/tb_aes_key_expand_128_top.sv
// Directed-vector bench for the AES-128 key expander and inverse S-box port.
module tb_aes_key_expand_128_top;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KZ_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] KZ_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    aes_key_expand_128_if bus ();

    aes_key_expand_128_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, obs);
        end
    endtask

    function automatic logic [127:0] wo_all();
        return {bus.wo_0, bus.wo_1, bus.wo_2, bus.wo_3};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse kld for one edge; returns at the negedge where round 0 is visible
    task automatic load_key(input logic [127:0] k);
        bus.kld = 1'b1;
        bus.key = k;
        step(1);
        bus.kld = 1'b0;
    endtask

    logic [7:0] isb_vec [5] = '{8'h63, 8'h00, 8'h16, 8'h01, 8'hff};
`ifdef AES_KEY_EXP_INV_SBOX_EN
    logic [7:0] isb_exp [5] = '{8'h00, 8'h52, 8'hff, 8'h09, 8'h7d};
`else
    logic [7:0] isb_exp [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif

    initial begin
        rst        = 1'b1;
        bus.kld    = 1'b0;
        bus.key    = '0;
        bus.isb_in = 8'h00;
        step(2);
        check_val("reset_wo", wo_all(), 128'h0);
        check_val("reset_rnd", 128'(bus.rnd), 128'd0);
        rst = 1'b0;
        step(3);
        check_val("post_reset_wo", wo_all(), 128'h0);

        // Standard FIPS-197 key
        load_key(K1);
        check_val("k1_r0_wo", wo_all(), K1);
        check_val("k1_r0_rnd", 128'(bus.rnd), 128'd0);
        step(1);
        check_val("k1_r1_wo", wo_all(), K1_R1);
        check_val("k1_r1_rnd", 128'(bus.rnd), 128'd1);
        step(9);
        check_val("k1_r10_wo", wo_all(), K1_R10);
        check_val("k1_r10_rnd", 128'(bus.rnd), 128'd10);
        step(5);
        check_val("k1_hold_wo", wo_all(), K1_R10);
        check_val("k1_hold_rnd", 128'(bus.rnd), 128'd10);

        // All-zero key
        load_key(128'h0);
        check_val("kz_r0_wo", wo_all(), 128'h0);
        step(1);
        check_val("kz_r1_wo", wo_all(), KZ_R1);
        step(9);
        check_val("kz_r10_wo", wo_all(), KZ_R10);
        check_val("kz_r10_rnd", 128'(bus.rnd), 128'd10);

        // Reload mid-expansion
        load_key(K1);
        step(4);
        check_val("mid_rnd4", 128'(bus.rnd), 128'd4);
        load_key(128'h0);
        check_val("restart_r0_wo", wo_all(), 128'h0);
        check_val("restart_r0_rnd", 128'(bus.rnd), 128'd0);
        step(1);
        check_val("restart_r1_wo", wo_all(), KZ_R1);
        step(9);
        check_val("restart_r10_wo", wo_all(), KZ_R10);
        step(2);
        check_val("restart_hold_rnd", 128'(bus.rnd), 128'd10);

        // Asynchronous reset mid-expansion
        load_key(K1);
        step(6);
        check_val("abort_rnd6", 128'(bus.rnd), 128'd6);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_wo", wo_all(), 128'h0);
        check_val("async_rst_rnd", 128'(bus.rnd), 128'd0);
        step(2);
        rst = 1'b0;
        step(3);
        check_val("after_abort_wo", wo_all(), 128'h0);
        check_val("after_abort_rnd", 128'(bus.rnd), 128'd0);

        // Reset wins over a simultaneous key load
        rst     = 1'b1;
        bus.kld = 1'b1;
        bus.key = K1;
        step(1);
        check_val("rst_over_kld_wo", wo_all(), 128'h0);
        rst     = 1'b0;
        bus.kld = 1'b0;
        step(2);
        check_val("rst_over_kld_idle", wo_all(), 128'h0);

        // Inverse S-box lookup port
        for (int i = 0; i < 5; i++) begin
            bus.isb_in = isb_vec[i];
            #1;
            check_val($sformatf("isb_%02h", isb_vec[i]), 128'(bus.isb_out), 128'(isb_exp[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/aes_key_expand_128_top.md
AES_KEY_EXPAND_128_TOP -- requirements
Module: aes_key_expand_128_top

Interface
REQ-001 Parameters: none; all widths fixed by AES-128.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 kld  input  1  key load strobe; samples key on the same edge.
REQ-005 key  input  128  cipher key, bits [127:96] = word 0 (FIPS-197 byte order, MSB first).
REQ-006 wo_0, wo_1, wo_2, wo_3  output  32 each  current round key words, driven directly from registers.
REQ-007 rnd  output  4  index of the round key currently on wo_0..wo_3 (0..10).
REQ-008 isb_in  input  8  byte for the inverse S-box lookup port.
REQ-009 isb_out  output  8  combinational inverse S-box of isb_in.

Function
REQ-010 kld=1 at an edge: {wo_0,wo_1,wo_2,wo_3} <= key, rnd <= 0, the running flag is set, and the internal rcon register <= 32'h01000000.
REQ-011 The block expands the key only while the running flag is set and kld=0.
REQ-012 Each expansion edge computes t = SubWord(RotWord(w3)) ^ rcon.
- w0' = w0^t, w1' = w0'^w1, w2' = w1'^w2, w3' = w2'^w3.
- rnd increments by 1.
- rcon advances through 01,02,04,08,10,20,40,80,1b,36 in the top byte; the lower 24 bits are 0.
REQ-013 Round key N appears N cycles after the kld edge. The latency from kld to round 0 is 1 edge, and to round 10 is 11 edges.
REQ-014 When rnd reaches 10, the running flag clears.
- wo_* and rnd then hold until the next kld or rst.
- The block never wraps to round 0 on its own.
REQ-015 kld asserted mid-expansion restarts at round 0 with the new key. kld has priority over expansion.
REQ-016 SubWord uses the forward AES S-box (FIPS-197) on each of the 4 bytes. RotWord rotates the word left by one byte.
REQ-017 isb_out is the FIPS-197 inverse S-box: purely combinational, zero latency, and independent of all other state.

Reset
REQ-018 rst=1 asynchronously sets wo_0..wo_3 to 0, rnd to 0, rcon to 0, and clears the running flag.
REQ-019 rst has priority over kld.
REQ-020 After rst deasserts, outputs hold 0 until kld is asserted.
REQ-021 Reset during expansion aborts it; no partial round key survives.

Configuration
REQ-022 Macro AES_KEY_EXP_INV_SBOX_EN controls the inverse S-box lookup port.
- Defined: isb_out implements the inverse S-box per REQ-017.
- Undefined: isb_out is tied to 8'h00 and no inverse S-box logic is instantiated.
- The port list is identical in both cases.

Structure
REQ-023 A shared package holds:
- the rcon table constant (10 entries);
- the round-count constant (10);
- the forward S-box table;
- the inverse S-box table.
REQ-024 One sub-module, aes_sbox (8-bit combinational forward S-box), is instantiated 4 times for SubWord.
REQ-025 The inverse S-box is a package function or case table inside the top, guarded by the macro.

Verification
REQ-026 kld with key 2b7e151628aed2a6abf7158809cf4f3c:
- 1 edge later: wo = same key, rnd=0;
- next edge: a0fafe17 88542cb1 23a33939 2a6c7605, rnd=1;
- 11 edges after kld: d014f9a8 c9ee2589 e13f0cc8 b6630ca6, rnd=10;
- 5 further edges: wo and rnd unchanged.
REQ-027 kld with key 0: round 1 = 62636363 62636363 62636363 62636363, and round 10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
REQ-028 Pulse kld with key 0 at rnd=4 of a 2b7e... expansion: the sequence restarts at round 0 with all-zero words, then proceeds per REQ-027.
REQ-029 Assert rst asynchronously (between edges) at rnd=6: all outputs read 0 immediately, and they stay 0 after release until kld.
REQ-030 With the macro defined, isb_in 63->00, 00->52, 16->ff, 01->09, ff->7d. With the macro undefined, isb_out = 00 for every input.
